// File: rtl/ysyx_25020037_ifu_fetch.sv
// Instruction fetch unit: issues one aligned fetch at a time to instruction
// memory and holds the fetched word until decode takes it. The next pc then
// comes from writeback. A misaligned pc or a memory access error produces a
// faulting instruction (inst=0) instead of a memory word.
module ysyx_25020037_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  // instruction memory request channel
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_req_addr,
  // instruction memory response channel
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             imem_rsp_err,
  // instruction channel to decode
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic             inst_fault,
  // next pc from writeback
  input  logic             npc_valid,
  input  logic [31:0]      npc,
  // completed instruction handshakes
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_WAIT_NPC
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      r_inst;
  logic [31:0]      r_inst_pc;
  logic             r_inst_fault;
  logic [CNT_W-1:0] r_fetch_cnt;

  logic w_misaligned;
  logic w_inst_fire;
  logic w_pc_load;

  assign w_misaligned = (r_pc[1:0] != 2'b00);
  assign w_inst_fire  = inst_valid & inst_ready;
  // A new pc is accepted together with the decode handshake or while parked
  // in WAIT_NPC; in every other state npc_valid is ignored.
  assign w_pc_load    = npc_valid & ((r_state == S_HOLD && inst_ready) ||
                                     (r_state == S_WAIT_NPC));

  assign imem_req_addr = r_pc;
  assign inst          = r_inst;
  assign inst_pc       = r_inst_pc;
  assign inst_fault    = r_inst_fault;
  assign fetch_cnt     = r_fetch_cnt;

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic and the handshake valids, which depend only on state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_nxt    = r_state;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_misaligned) begin
          w_state_nxt = S_HOLD;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: if (imem_rsp_valid) w_state_nxt = S_HOLD;
      S_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) w_state_nxt = npc_valid ? S_REQ : S_WAIT_NPC;
      end
      S_WAIT_NPC: if (npc_valid) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Program counter: loaded from writeback, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_pc <= RESET_PC;
    else if (w_pc_load) r_pc <= npc;
  end

  // Instruction holding register: captures a memory response or a
  // misalignment fault and stays stable until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_fault <= 1'b0;
    end else if (r_state == S_REQ && w_misaligned) begin
      r_inst       <= '0;
      r_inst_pc    <= r_pc;
      r_inst_fault <= 1'b1;
    end else if (r_state == S_WAIT && imem_rsp_valid) begin
      r_inst       <= imem_rsp_err ? 32'h0 : imem_rsp_data;
      r_inst_pc    <= r_pc;
      r_inst_fault <= imem_rsp_err;
    end
  end

  // Retired-fetch counter, wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_fetch_cnt <= '0;
    else if (w_inst_fire) r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_ysyx_25020037_ifu_fetch.sv
// Self-checking bench for the fetch unit. The bench plays memory, decode and
// writeback; each fetch is described as one transaction (pc, data, error,
// stall lengths) and the expected outputs follow from the fetch rules.
module tb_ysyx_25020037_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          CNT_W    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             imem_req_valid;
  logic             imem_req_ready = 1'b0;
  logic [31:0]      imem_req_addr;
  logic             imem_rsp_valid = 1'b0;
  logic [31:0]      imem_rsp_data = '0;
  logic             imem_rsp_err = 1'b0;
  logic             inst_valid;
  logic             inst_ready = 1'b0;
  logic [31:0]      inst;
  logic [31:0]      inst_pc;
  logic             inst_fault;
  logic             npc_valid = 1'b0;
  logic [31:0]      npc = '0;
  logic [CNT_W-1:0] fetch_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cur_pc;   // pc the model expects the next fetch to use
  int          exp_cnt;  // total handshakes since reset (unbounded)

  ysyx_25020037_ifu_fetch #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_fault    (inst_fault),
    .npc_valid     (npc_valid),
    .npc           (npc),
    .fetch_cnt     (fetch_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Counter value expected on the 4-bit output: the count modulo 16.
  function automatic logic [CNT_W-1:0] cnt_model();
    return CNT_W'(exp_cnt % (1 << CNT_W));
  endfunction

  // Compare all outputs against their reset values.
  task automatic check_reset_outputs(input string tag);
    n_tests++;
    if ({imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_fault, fetch_cnt} !==
        {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL %s: got req_v=%b addr=%h inst_v=%b inst=%h pc=%h fault=%b cnt=%0d, want reset values",
               tag, imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_fault, fetch_cnt);
    end
  endtask

  // One complete fetch transaction starting with the DUT in REQ at cur_pc.
  // The DUT must present the request, take the response, hold the
  // instruction for decode and then follow writeback to nxt.
  task automatic fetch_one(input logic [31:0] data, input bit err,
                           input int ready_lag, input int rsp_lag, input int ack_lag,
                           input bit npc_same, input logic [31:0] nxt, input int npc_lag);
    bit          aligned;
    logic [31:0] exp_inst;
    aligned  = (cur_pc % 4) == 0;
    exp_inst = (aligned && !err) ? data : 32'h0;
    if (aligned) begin
      for (int k = 0; k <= ready_lag; k++) begin
        n_tests++;
        if ({imem_req_valid, imem_req_addr, inst_valid, fetch_cnt} !== {1'b1, cur_pc, 1'b0, cnt_model()}) begin
          n_fail++;
          $display("FAIL req: got v=%b addr=%h inst_v=%b cnt=%0d, want v=1 addr=%h inst_v=0 cnt=%0d",
                   imem_req_valid, imem_req_addr, inst_valid, fetch_cnt, cur_pc, cnt_model());
        end
        imem_req_ready = (k == ready_lag);
        imem_rsp_valid = 1'($urandom_range(1));  // stray responses are ignored
        imem_rsp_data  = $urandom;
        npc_valid      = 1'($urandom_range(1));  // writeback strobes are ignored
        npc            = $urandom;
        @(negedge clk);
      end
      imem_req_ready = 1'b0;
      npc_valid      = 1'b0;
      imem_rsp_valid = 1'b0;
      for (int k = 0; k <= rsp_lag; k++) begin
        n_tests++;
        if ({imem_req_valid, inst_valid} !== 2'b00) begin
          n_fail++;
          $display("FAIL wait: got req_v=%b inst_v=%b, want 0 0", imem_req_valid, inst_valid);
        end
        imem_rsp_valid = (k == rsp_lag);
        imem_rsp_data  = data;
        imem_rsp_err   = err;
        npc_valid      = 1'($urandom_range(1));
        npc            = $urandom;
        @(negedge clk);
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
    end else begin
      n_tests++;
      if (imem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL misaligned_req: got req_v=%b, want 0 at pc %h", imem_req_valid, cur_pc);
      end
      imem_req_ready = 1'($urandom_range(1));
      @(negedge clk);
      imem_req_ready = 1'b0;
    end
    for (int k = 0; k <= ack_lag; k++) begin
      n_tests++;
      if ({inst_valid, inst, inst_pc, inst_fault, imem_req_valid, fetch_cnt} !==
          {1'b1, exp_inst, cur_pc, !aligned || err, 1'b0, cnt_model()}) begin
        n_fail++;
        $display("FAIL hold: got v=%b inst=%h pc=%h fault=%b req_v=%b cnt=%0d, want v=1 inst=%h pc=%h fault=%b req_v=0 cnt=%0d",
                 inst_valid, inst, inst_pc, inst_fault, imem_req_valid, fetch_cnt,
                 exp_inst, cur_pc, !aligned || err, cnt_model());
      end
      inst_ready     = (k == ack_lag);
      npc_valid      = (k == ack_lag) ? npc_same : 1'($urandom_range(1));
      npc            = (k == ack_lag) ? nxt : $urandom;
      imem_rsp_valid = 1'($urandom_range(1));
      @(negedge clk);
    end
    exp_cnt++;
    inst_ready     = 1'b0;
    npc_valid      = 1'b0;
    imem_rsp_valid = 1'b0;
    if (!npc_same) begin
      for (int k = 0; k <= npc_lag; k++) begin
        n_tests++;
        if ({inst_valid, imem_req_valid, fetch_cnt} !== {1'b0, 1'b0, cnt_model()}) begin
          n_fail++;
          $display("FAIL wait_npc: got inst_v=%b req_v=%b cnt=%0d, want 0 0 %0d",
                   inst_valid, imem_req_valid, fetch_cnt, cnt_model());
        end
        npc_valid      = (k == npc_lag);
        npc            = nxt;
        imem_rsp_valid = 1'($urandom_range(1));
        @(negedge clk);
      end
      npc_valid      = 1'b0;
      imem_rsp_valid = 1'b0;
    end
    cur_pc = nxt;
  endtask

  // Reset values while rst_n is low, IDLE for one cycle after release.
  task automatic test_reset();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
    npc_valid      = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_async");
    @(negedge clk);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    n_tests++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got req_v=%b, want 0", imem_req_valid);
    end
    @(negedge clk);
    cur_pc  = RESET_PC;
    exp_cnt = 0;
  endtask

  task automatic test_basic();
    fetch_one(32'h0000_0413, 1'b0, 0, 0, 0, 1'b0, 32'h8000_0004, 1);
  endtask

  task automatic test_backpressure();
    fetch_one($urandom, 1'b0, 3, 0, 4, 1'b0, 32'h8000_0008, 0);
  endtask

  task automatic test_npc_same_cycle();
    fetch_one($urandom, 1'b0, 0, 1, 0, 1'b1, 32'h8000_0010, 0);
    fetch_one($urandom, 1'b0, 1, 0, 0, 1'b0, 32'h8000_0006, 2);
  endtask

  task automatic test_misaligned();
    fetch_one($urandom, 1'b0, 0, 0, 1, 1'b0, 32'h8000_0020, 0);
  endtask

  task automatic test_error();
    fetch_one(32'hDEAD_BEEF, 1'b1, 0, 0, 0, 1'b0, 32'h8000_0024, 0);
  endtask

  // Reset during WAIT discards the fetch; a late response is ignored and the
  // unit refetches from RESET_PC.
  task automatic test_reset_in_wait();
    n_tests++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, cur_pc}) begin
      n_fail++;
      $display("FAIL rw_req: got v=%b addr=%h, want 1 %h", imem_req_valid, imem_req_addr, cur_pc);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rw_reset");
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if ({imem_req_valid, imem_req_addr, inst_valid, inst, fetch_cnt} !==
          {1'b1, RESET_PC, 1'b0, 32'h0, 4'h0}) begin
        n_fail++;
        $display("FAIL rw_stray: got req_v=%b addr=%h inst_v=%b inst=%h cnt=%0d, want 1 %h 0 0 0",
                 imem_req_valid, imem_req_addr, inst_valid, inst, fetch_cnt, RESET_PC);
      end
      @(negedge clk);
    end
    imem_rsp_valid = 1'b0;
    cur_pc = RESET_PC;
    fetch_one(32'h0000_0013, 1'b0, 0, 0, 0, 1'b0, 32'h8000_0004, 0);
  endtask

  // 17 handshakes on a 4-bit counter leave it at 1.
  task automatic test_wrap();
    test_reset();
    for (int i = 0; i < 17; i++)
      fetch_one($urandom, 1'b0, 0, 0, 0, 1'(i % 2), cur_pc + 32'd4, 0);
    n_tests++;
    if (fetch_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL wrap: got cnt=%0d, want 1", fetch_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] nxt;
    for (int i = 0; i < 40; i++) begin
      nxt = 32'h8000_0000 + ($urandom_range(255) * 4);
      if ($urandom_range(5) == 0) nxt = nxt + 32'($urandom_range(3));
      fetch_one($urandom, ($urandom_range(4) == 0), $urandom_range(3), $urandom_range(3),
                $urandom_range(3), 1'($urandom_range(1)), nxt, $urandom_range(3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_npc_same_cycle();
    test_misaligned();
    test_error();
    test_reset_in_wait();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
